// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    function automatic int numChunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter is kept at least one bit wide so the N=1 build still has a legal index.
    function automatic int cntWidth(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Start/busy/done handshake and operand/result bus of the chunked adder.
// iSUB exists only when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             iSTART;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iCIN;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             iSUB;
`endif
    logic             oBUSY;
    logic             oDONE;
    logic [WIDTH-1:0] oSUM;
    logic             oCARRY;
    logic             oOVF;

`ifdef CHUNKED_ADDER_SUB_EN
    modport master (output iSTART, iA, iB, iCIN, iSUB,
                    input  oBUSY, oDONE, oSUM, oCARRY, oOVF);
    modport slave  (input  iSTART, iA, iB, iCIN, iSUB,
                    output oBUSY, oDONE, oSUM, oCARRY, oOVF);
`else
    modport master (output iSTART, iA, iB, iCIN,
                    input  oBUSY, oDONE, oSUM, oCARRY, oOVF);
    modport slave  (input  iSTART, iA, iB, iCIN,
                    output oBUSY, oDONE, oSUM, oCARRY, oOVF);
`endif

endinterface

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-bit slice adder; also reports the carry into its MSB
// so the top level can derive signed overflow on the last slice.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cMsb
);
    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // A sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign cMsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock, carry held in a register
// between slices. Define CHUNKED_ADDER_SUB_EN to add the iSUB subtract mode.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic            iCLK,
    input logic            iRST_N,
    chunked_adder_if.slave bus
);
    localparam int N  = numChunks(WIDTH, CHUNK);
    localparam int CW = cntWidth(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    stateT            state;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] sumWork;
    logic [WIDTH-1:0] nextWork;
    logic             carry;
    logic             subSel;
    logic [CHUNK-1:0] aSlice;
    logic [CHUNK-1:0] bSlice;
    logic [CHUNK-1:0] chunkSum;
    logic             chunkCout;
    logic             chunkCmsb;

`ifdef CHUNKED_ADDER_SUB_EN
    assign subSel = bus.iSUB;
`else
    assign subSel = 1'b0;
`endif

    always_comb begin
        aSlice   = opA[k*CHUNK +: CHUNK];
        bSlice   = opB[k*CHUNK +: CHUNK];
        nextWork = sumWork;
        nextWork[k*CHUNK +: CHUNK] = chunkSum;
    end

    chunk_add #(.CHUNK(CHUNK)) uChunkAdd (
        .a    (aSlice),
        .b    (bSlice),
        .cin  (carry),
        .sum  (chunkSum),
        .cout (chunkCout),
        .cMsb (chunkCmsb)
    );

    // Subtraction is folded in at capture (A + ~B + ~cin), so RUN only ever adds.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            k          <= '0;
            opA        <= '0;
            opB        <= '0;
            sumWork    <= '0;
            carry      <= 1'b0;
            bus.oSUM   <= '0;
            bus.oCARRY <= 1'b0;
            bus.oOVF   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        opA     <= bus.iA;
                        opB     <= subSel ? ~bus.iB : bus.iB;
                        carry   <= subSel ? ~bus.iCIN : bus.iCIN;
                        sumWork <= '0;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sumWork <= nextWork;
                    carry   <= chunkCout;
                    if (k == LAST) begin
                        k          <= '0;
                        state      <= DONE;
                        bus.oSUM   <= nextWork;
                        bus.oCARRY <= chunkCout;
                        bus.oOVF   <= chunkCmsb ^ chunkCout;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oBUSY = (state != IDLE);
    assign bus.oDONE = (state == DONE);

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (N=4 and N=1 builds) with a result scoreboard.
module tb_chunked_adder;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } resT;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   failures = 0;
    resT  sb[$];

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus4 ();
    chunked_adder_if #(.WIDTH(16)) bus16 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (bus4)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (bus16)
    );

    // Reference: full-width add of A, effective B and effective carry-in.
    function automatic resT model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
        resT         r;
        logic [15:0] bEff;
        logic        cEff;
        logic [16:0] full;
        bEff    = sub ? ~b : b;
        cEff    = sub ? ~cin : cin;
        full    = {1'b0, a} + {1'b0, bEff} + {16'd0, cEff};
        r.sum   = full[15:0];
        r.carry = full[16];
        r.ovf   = (a[15] == bEff[15]) && (r.sum[15] != a[15]);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
        bus4.iA     = a;
        bus4.iB     = b;
        bus4.iCIN   = cin;
`ifdef CHUNKED_ADDER_SUB_EN
        bus4.iSUB   = sub;
`endif
        bus4.iSTART = 1'b1;
        sb.push_back(model(a, b, cin, sub));
        @(negedge clk);
        bus4.iSTART = 1'b0;
        checkOutput("busy_after_start", bus4.oBUSY, 1);
    endtask

    // Called on the negedge after the start edge; latency counted in clock edges.
    task automatic waitResult(input string tag, input int expLat);
        int  lat;
        resT e;
        lat = 0;
        while (!bus4.oDONE && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL %s_scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_sum"},   bus4.oSUM,   e.sum);
            checkOutput({tag, "_carry"}, bus4.oCARRY, e.carry);
            checkOutput({tag, "_ovf"},   bus4.oOVF,   e.ovf);
            @(negedge clk);
            checkOutput({tag, "_done_width"}, bus4.oDONE, 0);
            checkOutput({tag, "_idle"},       bus4.oBUSY, 0);
            checkOutput({tag, "_sum_held"},   bus4.oSUM,  e.sum);
        end
    endtask

    initial begin
        int  sawDone;
        int  lat;
        resT e;

        bus4.iSTART  = 1'b0;
        bus4.iA      = '0;
        bus4.iB      = '0;
        bus4.iCIN    = 1'b0;
        bus16.iSTART = 1'b0;
        bus16.iA     = '0;
        bus16.iB     = '0;
        bus16.iCIN   = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
        bus4.iSUB    = 1'b0;
        bus16.iSUB   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_busy",  bus4.oBUSY,  0);
        checkOutput("reset_done",  bus4.oDONE,  0);
        checkOutput("reset_sum",   bus4.oSUM,   0);
        checkOutput("reset_carry", bus4.oCARRY, 0);
        checkOutput("reset_ovf",   bus4.oOVF,   0);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        waitResult("basic", 4);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitResult("wrap", 4);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitResult("ovf", 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'b0);
            waitResult("random", 4);
        end

        // Start held high with operands swapped while busy: second op runs after the IDLE cycle.
        bus4.iA     = 16'h1111;
        bus4.iB     = 16'h2222;
        bus4.iCIN   = 1'b0;
        bus4.iSTART = 1'b1;
        sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
        @(negedge clk);
        bus4.iA   = 16'h0F0F;
        bus4.iB   = 16'h0101;
        bus4.iCIN = 1'b1;
        sb.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
        checkOutput("hold_busy", bus4.oBUSY, 1);
        waitResult("hold_first", 4);
        @(negedge clk);
        checkOutput("hold_accept", bus4.oBUSY, 1);
        bus4.iSTART = 1'b0;
        waitResult("hold_second", 4);

        applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abort_sum",   bus4.oSUM,   0);
        checkOutput("abort_busy",  bus4.oBUSY,  0);
        checkOutput("abort_carry", bus4.oCARRY, 0);
        checkOutput("abort_ovf",   bus4.oOVF,   0);
        sb.delete();
        @(negedge clk);
        rstN = 1'b1;
        sawDone = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus4.oDONE) sawDone = 1;
        end
        checkOutput("abort_no_done", sawDone, 0);
        applyStimulus(16'h0001, 16'h0002, 1'b1, 1'b0);
        waitResult("after_abort", 4);

        bus16.iA     = 16'h8000;
        bus16.iB     = 16'h8000;
        bus16.iCIN   = 1'b1;
        bus16.iSTART = 1'b1;
        e = model(16'h8000, 16'h8000, 1'b1, 1'b0);
        @(negedge clk);
        bus16.iSTART = 1'b0;
        lat = 0;
        while (!bus16.oDONE && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("n1_latency", lat, 1);
        checkOutput("n1_sum",   bus16.oSUM,   e.sum);
        checkOutput("n1_carry", bus16.oCARRY, e.carry);
        checkOutput("n1_ovf",   bus16.oOVF,   e.ovf);
        @(negedge clk);
        checkOutput("n1_done_width", bus16.oDONE, 0);

`ifdef CHUNKED_ADDER_SUB_EN
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
        waitResult("sub_borrow", 4);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
        waitResult("sub_ovf", 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
